// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe_reg
// Function : Elastic valid/ready inter-stage register with a 2-entry skid
//            buffer, flush, sticky HALT and bubble-safe control-bit zeroing.
//            Optional stall counter enabled by ELASTIC_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_pipe_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8
`ifdef ELASTIC_STALL_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic              halted,
    output logic [1:0]        occupancy
`ifdef ELASTIC_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam logic [DATA_W:0]   c_ONE       = (DATA_W + 1)'(1);
    localparam logic [DATA_W-1:0] c_CTRL_MASK = DATA_W'((c_ONE << CTRL_W) - c_ONE);

    logic              r_mainValid, r_mainHalt;
    logic [DATA_W-1:0] r_mainData;
    logic              r_skidValid, r_skidHalt;
    logic [DATA_W-1:0] r_skidData;
    logic              r_halted;
    logic [1:0]        r_occupancy;

    logic              w_accept, w_consume;
    logic              w_mainValidNext, w_mainHaltNext;
    logic [DATA_W-1:0] w_mainDataNext;
    logic              w_skidValidNext, w_skidHaltNext;
    logic [DATA_W-1:0] w_skidDataNext;
    logic              w_haltedNext;
    logic [1:0]        w_occupancyNext;

    // in_ready decodes registers only, so there is no path from out_ready.
    assign in_ready  = !r_skidValid && !r_halted;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_mainValid && out_ready;

    always_comb begin
        w_mainValidNext = r_mainValid;
        w_mainHaltNext  = r_mainHalt;
        w_mainDataNext  = r_mainData;
        w_skidValidNext = r_skidValid;
        w_skidHaltNext  = r_skidHalt;
        w_skidDataNext  = r_skidData;
        w_haltedNext    = r_halted;
        if (flush) begin
            w_mainValidNext = 1'b0;
            w_skidValidNext = 1'b0;
        end else begin
            if (w_accept && in_halt) begin
                w_haltedNext = 1'b1;
            end
            if (!r_mainValid || w_consume) begin
                if (r_skidValid) begin
                    w_mainValidNext = 1'b1;
                    w_mainHaltNext  = r_skidHalt;
                    w_mainDataNext  = r_skidData;
                    w_skidValidNext = 1'b0;
                end else if (w_accept) begin
                    w_mainValidNext = 1'b1;
                    w_mainHaltNext  = in_halt;
                    w_mainDataNext  = in_data;
                end else begin
                    w_mainValidNext = 1'b0;
                end
            end else if (w_accept) begin
                w_skidValidNext = 1'b1;
                w_skidHaltNext  = in_halt;
                w_skidDataNext  = in_data;
            end
        end
        w_occupancyNext = {1'b0, w_mainValidNext} + {1'b0, w_skidValidNext};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mainValid <= 1'b0;
            r_mainHalt  <= 1'b0;
            r_mainData  <= '0;
            r_skidValid <= 1'b0;
            r_skidHalt  <= 1'b0;
            r_skidData  <= '0;
            r_halted    <= 1'b0;
            r_occupancy <= 2'd0;
        end else begin
            r_mainValid <= w_mainValidNext;
            r_mainHalt  <= w_mainHaltNext;
            r_mainData  <= w_mainDataNext;
            r_skidValid <= w_skidValidNext;
            r_skidHalt  <= w_skidHaltNext;
            r_skidData  <= w_skidDataNext;
            r_halted    <= w_haltedNext;
            r_occupancy <= w_occupancyNext;
        end
    end

    // Bubbles must not carry live enables downstream; upper bits keep stale data.
    assign out_valid = r_mainValid;
    assign out_data  = r_mainValid ? r_mainData : (r_mainData & ~c_CTRL_MASK);
    assign out_halt  = r_mainHalt && r_mainValid;
    assign halted    = r_halted;
    assign occupancy = r_occupancy;

`ifdef ELASTIC_STALL_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stallCnt <= '0;
        end else if (r_mainValid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
`default_nettype none
// Testbench for elastic_pipe_reg: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_elastic_pipe_reg;

    localparam int DW = 32;
    localparam int CW = 8;
`ifdef ELASTIC_STALL_CNT_EN
    localparam int CNTW = 2;
`endif

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_halt = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_halt, halted;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef ELASTIC_STALL_CNT_EN
    logic [CNTW-1:0] stall_cnt;
`endif

    elastic_pipe_reg #(
        .DATA_W (DW),
        .CTRL_W (CW)
`ifdef ELASTIC_STALL_CNT_EN
        ,
        .CNT_W  (CNTW)
`endif
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_halt   (in_halt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_halt  (out_halt),
        .halted    (halted),
        .occupancy (occupancy)
`ifdef ELASTIC_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          halt;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        q[$];
    bit            mHalted = 1'b0;
    logic [DW-1:0] mLast = '0;
    int            mStall = 0;
    int            nChecks = 0;
    int            nFails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] expData();
        if (q.size() != 0) return q[0].data;
        return (mLast >> CW) << CW;
    endfunction

    task automatic checkOutputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        check({tag, ".out_data"},  64'(out_data),  64'(expData()));
        check({tag, ".out_halt"},  64'(out_halt),  64'(q.size() != 0 && q[0].halt));
        check({tag, ".halted"},    64'(halted),    64'(mHalted));
        check({tag, ".occupancy"}, 64'(occupancy), 64'(q.size()));
        check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2 && !mHalted));
`ifdef ELASTIC_STALL_CNT_EN
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(mStall));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check on negedge.
    task automatic step(input string tag, input bit v, input logic [DW-1:0] d,
                        input bit h, input bit f, input bit r);
        bit acc, cons;
        in_valid  = v;
        in_data   = d;
        in_halt   = h;
        flush     = f;
        out_ready = r;
        acc  = v && (q.size() < 2) && !mHalted;
        cons = (q.size() != 0) && r;
        @(posedge CLK);
`ifdef ELASTIC_STALL_CNT_EN
        if (q.size() != 0 && !r && mStall < (2 ** CNTW) - 1) mStall++;
`endif
        if (f) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) begin
                q.push_back({h, d});
                if (h) mHalted = 1'b1;
            end
        end
        if (q.size() != 0) mLast = q[0].data;
        @(negedge CLK);
        checkOutputs(tag);
    endtask

    task automatic modelReset();
        q.delete();
        mHalted = 1'b0;
        mLast   = '0;
        mStall  = 0;
    endtask

    initial begin
        // Reset values while nRST is held low
        #12;
        checkOutputs("reset");
        @(negedge CLK);
        nRST = 1'b1;

        // Streaming at full rate
        step("stream0", 1, 32'h11, 0, 0, 1);
        step("stream1", 1, 32'h22, 0, 0, 1);
        step("stream2", 1, 32'h33, 0, 0, 1);
        step("stream3", 1, 32'h44, 0, 0, 1);
        step("stream4", 0, 32'h0,  0, 0, 1);

        // Back-pressure: A3 held off until the skid frees up
        step("bp0", 1, 32'hA1, 0, 0, 0);
        step("bp1", 1, 32'hA2, 0, 0, 0);
        step("bp2", 1, 32'hA3, 0, 0, 0);
        step("bp3", 1, 32'hA3, 0, 0, 1);
        step("bp4", 1, 32'hA3, 0, 0, 1);
        step("bp5", 0, 32'h0,  0, 0, 1);
        step("bp6", 0, 32'h0,  0, 0, 1);

        // Flush while full with a simultaneous offer
        step("fl0", 1, 32'h1234_56B1, 0, 0, 0);
        step("fl1", 1, 32'h1234_56B2, 0, 0, 0);
        step("fl2", 1, 32'h1234_56BB, 0, 1, 1);
        step("fl3", 0, 32'h0, 0, 0, 1);

        // Random traffic, no HALT
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), $urandom,
                 0, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset while full, between clock edges
        step("ar0", 1, 32'hC1, 0, 0, 0);
        step("ar1", 1, 32'hC2, 0, 0, 0);
        step("ar2", 0, 32'h0,  0, 0, 0);
        in_valid = 0;
        #2;
        nRST = 1'b0;
        #1;
        modelReset();
        checkOutputs("asyncrst");
        @(negedge CLK);
        nRST = 1'b1;
        step("ar3", 0, 32'h0, 0, 0, 1);

        // HALT: sticky, further offers ignored, halt flag travels with payload
        step("h0", 1, 32'h77, 0, 0, 0);
        step("h1", 1, 32'h55, 1, 0, 0);
        step("h2", 1, 32'h66, 0, 0, 0);
        step("h3", 1, 32'h66, 0, 0, 1);
        step("h4", 1, 32'h66, 0, 0, 1);
        step("h5", 1, 32'h66, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step("hrand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 0, 1'($urandom_range(0, 1)));
        end

        // Reset clears halted; then hold a stalled output (stall counter saturation)
        @(negedge CLK);
        nRST = 1'b0;
        modelReset();
        @(negedge CLK);
        checkOutputs("rst2");
        nRST = 1'b1;
        step("st0", 1, 32'h99, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("stall", 0, 32'h0, 0, 0, 0);
        end
        step("st1", 0, 32'h0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised, elastic successor to the fixed-field inter-stage latches (EX/M style).
- Carries an opaque DATA_W payload between two pipeline stages using a valid/ready handshake, backed by a 2-entry skid buffer.
- Supports flush, stall back-pressure, a sticky HALT, and bubble-safe zeroing of control bits.
- Any stage boundary (IF/ID, ID/EX, EX/M, M/WB) is instantiated with its own packed struct width.

Parameters:
- DATA_W, 128: payload width in bits; the packed stage struct is mapped onto it.
- CTRL_W, 8: number of low payload bits that are control enables (dREN, dWEN, WEN, ...); forced to 0 whenever out_valid is 0.
- CNT_W, 16: stall counter width (optional feature only).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage presents a payload.
- in_ready  out  1  this block can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  payload is a HALT instruction.
- flush  in  1  squash all held entries (branch/jump resolution).
- out_valid  out  1  output payload is valid.
- out_ready  in  1  downstream consumes the payload this cycle.
- out_data  out  DATA_W  payload to the downstream stage.
- out_halt  out  1  HALT flag of the output payload.
- halted  out  1  sticky: a HALT has been accepted.
- occupancy  out  2  number of entries held (0..2).
- stall_cnt  out  CNT_W  present only with the optional feature.

Behaviour:
- Storage: main entry (drives the outputs) and skid entry. Each entry holds {valid, halt, data}.
- Reset (nRST=0, asynchronous): both entries invalid; data zero; halted=0.
  - Outputs during reset: out_valid=0, out_data=0, out_halt=0, in_ready=1, occupancy=0, stall_cnt=0.
- Accept: in_valid & in_ready. Consume: out_valid & out_ready. Both evaluated on the same edge.
- in_ready = !skid.valid & !halted. It is a pure register decode with no combinational path from out_ready.
- Latency: payload accepted at edge N appears on out_data after edge N when the main entry is empty or consumed at edge N. Throughput is 1 per cycle with no bubbles.
- Transitions, per edge, by occupancy:
  - EMPTY (0): accept -> main. Occupancy becomes 1.
  - ONE (1):
    - accept & consume -> main replaced; stays 1.
    - accept only -> skid; becomes 2.
    - consume only -> becomes 0.
  - FULL (2): in_ready=0.
    - consume -> skid moves to main; skid cleared; becomes 1.
- Flush has priority over every simultaneous accept and consume.
  - Next state: both entries invalid, occupancy 0.
  - A payload offered in the flush cycle is dropped.
  - halted is not cleared by flush.
- Bubble rule: when out_valid=0, out_data[CTRL_W-1:0]=0. Upper bits hold their last value.
- HALT handling:
  - Accepting a payload with in_halt=1 sets halted at that edge.
  - Once halted is set, in_ready=0 and no further accepts occur until reset.
  - out_halt = main.halt & out_valid.
  - An entry with halt=1 is consumed normally.
- A reset asserted mid-transfer discards all entries immediately. There is no partial-state retention.
- occupancy is registered and always equals main.valid + skid.valid.

Optional Feature:
- Macro: ELASTIC_STALL_CNT_EN.
- Defined:
  - stall_cnt increments (saturating at all-ones) on every edge where out_valid & !out_ready.
  - Reset to 0 by nRST only.
  - Port is present.
- Undefined:
  - stall_cnt port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Streaming: out_ready=1; in_valid=1 for 4 cycles with data 0x11, 0x22, 0x33, 0x44 -> out_data shows the same values on the 4 following cycles; occupancy stays at 1 or below; in_ready stays 1.
- Back-pressure: out_ready=0; offer 0xA1, then 0xA2, then 0xA3 -> occupancy goes 1, 2; in_ready=0 on the 3rd cycle so 0xA3 is held off. Release out_ready -> outputs are 0xA1, 0xA2, 0xA3 in order, with no loss or duplication.
- Flush with simultaneous accept: occupancy=2 plus in_valid=1 and flush=1 -> next cycle occupancy=0, out_valid=0, out_data[7:0]=0; the offered payload never appears.
- HALT: accept 0x55 with in_halt=1 -> halted=1 and in_ready=0 from the next cycle. When 0x55 reaches the output, out_halt=1. Further in_valid is ignored.
- Async reset mid-stream: drop nRST between clock edges while occupancy=2 -> outputs go to their reset values immediately, without waiting for CLK.
- ELASTIC_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. With CNT_W=2, 5 stall cycles -> stall_cnt saturates at 3.
